// File: rtl/ll_fifo_pkg.sv
// Shared types for the linked-list fifo drain engine: queue ids, output
// buffer entries and the round-robin pointer advance.
package ll_fifo_pkg;
  localparam int LL_WIDTH      = 8;
  localparam int LL_NUM_FIFOS  = 2;
  localparam int LL_OBUF_DEPTH = 3;
  localparam int LL_ID_WIDTH   = (LL_NUM_FIFOS > 1) ? $clog2(LL_NUM_FIFOS) : 1;

  typedef logic [LL_ID_WIDTH-1:0] qid_t;

  typedef struct packed {
    logic [LL_WIDTH-1:0] data;
    qid_t                id;
  } obuf_entry_t;

  function automatic qid_t next_rr(input qid_t ptr);
    return (ptr == qid_t'(LL_NUM_FIFOS-1)) ? '0 : qid_t'(ptr + 1'b1);
  endfunction
endpackage

// File: rtl/ll_fifo_drain_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr,
// wrapping modulo the queue count.
module rr_arbiter
  import ll_fifo_pkg::*;
(
  input  logic [LL_NUM_FIFOS-1:0] req,
  input  qid_t                    ptr,
  output logic [LL_NUM_FIFOS-1:0] grant,
  output qid_t                    grant_idx,
  output logic                    gnt_vld
);
  localparam int SW = LL_ID_WIDTH + 1;

  always_comb begin
    logic [SW-1:0] sum;
    qid_t          idx;
    grant     = '0;
    grant_idx = '0;
    gnt_vld   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < LL_NUM_FIFOS; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(LL_NUM_FIFOS)) sum = sum - SW'(LL_NUM_FIFOS);
      idx = sum[LL_ID_WIDTH-1:0];
      if (!gnt_vld && req[idx]) begin
        gnt_vld    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/ll_fifo_drain_arb.sv
// Read-side engine for the shared linked-list fifo: round-robin pops,
// fixed-latency capture into a small circular buffer, valid/ready output.
module ll_fifo_drain_arb
  import ll_fifo_pkg::*;
#(
  // Sizes must match the ll_fifo_pkg types they feed.
  parameter int WIDTH      = LL_WIDTH,
  parameter int NUM_FIFOS  = LL_NUM_FIFOS,
  parameter int OBUF_DEPTH = LL_OBUF_DEPTH,
  parameter int ID_WIDTH   = LL_ID_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_FIFOS-1:0] pop_mask,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic [NUM_FIFOS-1:0] pop,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]  out_id
);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int OW = $clog2(OBUF_DEPTH + 1);

  qid_t          rr_ptr, inflight_id, grant_idx;
  logic          inflight, gnt_vld, issue, wr_en, rd_en;
  logic [NUM_FIFOS-1:0] grant;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [OW:0]   committed;
  obuf_entry_t   mem [OBUF_DEPTH];

  rr_arbiter u_arb (
    .req       (~empty & pop_mask),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .gnt_vld   (gnt_vld)
  );

  // A same-cycle dequeue is not credited, so a slot always exists for the capture.
  assign committed = {1'b0, occ} + {{OW{1'b0}}, inflight};
  assign issue     = !rst && enable && gnt_vld && (committed < (OW+1)'(OBUF_DEPTH));
  assign pop       = issue ? grant : '0;

  assign wr_en    = inflight;
  assign out_vld  = (occ != '0);
  assign rd_en    = out_vld && out_rdy;
  assign out_data = mem[rd_ptr].data;
  assign out_id   = mem[rd_ptr].id;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH-1)) ? '0 : PW'(p + 1'b1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      mem         <= '{default: '0};
    end else begin
      if (issue) begin
        rr_ptr      <= next_rr(grant_idx);
        inflight_id <= grant_idx;
      end
      inflight <= issue;
      if (wr_en) begin
        mem[wr_ptr] <= '{data: fifo_data, id: inflight_id};
        wr_ptr      <= inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(inflight && occ == OW'(OBUF_DEPTH)));
  end
endmodule

// File: tb/tb_ll_fifo_drain_arb.sv
// Randomized bench with a queue-level model of the fifo, pipeline and buffer.
module tb_ll_fifo_drain_arb;
  localparam int W = 8, NF = 2, D = 3;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, out_rdy = 1'b0;
  logic [NF-1:0] pop_mask = '1, empty = '1, pop;
  logic [W-1:0]  fifo_data = '0, out_data;
  logic          out_vld;
  logic [0:0]    out_id;

  ll_fifo_drain_arb dut (
    .clk(clk), .rst(rst), .enable(enable), .pop_mask(pop_mask), .empty(empty),
    .fifo_data(fifo_data), .pop(pop), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int fq[NF][$];
  int exp_q[$];          // buffered words, encoded id*256+data
  int pop_log[$], out_log[$];
  int pend = 0, rr = 0;
  bit pend_v = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    int g, idx;
    logic [NF-1:0] req;
    bit deq;
    for (int q = 0; q < NF; q++) empty[q] = (fq[q].size() == 0);
    #1;
    req = ~empty & pop_mask;
    g = -1;
    if (!rst && enable && (exp_q.size() + int'(pend_v)) < D)
      for (int i = 0; i < NF; i++) begin
        idx = (rr + i) % NF;
        if (g < 0 && ((req >> idx) & 1) != 0) g = idx;
      end
    chk("pop", int'(pop), (g < 0) ? 0 : (1 << g));
    chk("out_vld", int'(out_vld), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", int'(out_data), exp_q[0] % 256);
      chk("out_id", int'(out_id), exp_q[0] / 256);
    end
    deq = (exp_q.size() != 0) && out_rdy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pend_v = 1'b0;
      rr = 0;
    end else begin
      if (deq) out_log.push_back(exp_q.pop_front());
      if (pend_v) exp_q.push_back(pend);
      pend_v = (g >= 0);
      if (g >= 0) begin
        pend = g * 256 + fq[g].pop_front();
        rr = (g + 1) % NF;
        pop_log.push_back(g);
      end
    end
    @(negedge clk);
    fifo_data = pend_v ? W'(pend % 256) : W'($urandom);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    out_log.delete();
  endtask

  initial begin
    int t2p[6];
    int t2o[6];
    int ones;
    t2p = '{0, 1, 0, 1, 0, 1};
    t2o = '{'hA0, 256 + 'hB0, 'hA1, 256 + 'hB1, 'hA2, 256 + 'hB2};

    // T1: reset with both queues non-empty
    for (int i = 0; i < 3; i++) begin
      fq[0].push_back('hA0 + i);
      fq[1].push_back('hB0 + i);
    end
    enable = 1'b1; out_rdy = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    repeat (2) begin
      chk("rst_out_data", int'(out_data), 0);
      tick();
    end
    rst = 1'b0;

    // T2: round-robin across two loaded queues
    clear_logs();
    repeat (10) tick();
    chk("t2_npops", pop_log.size(), 6);
    chk("t2_nouts", out_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pop_log.size()) chk("t2_pop_order", pop_log[i], t2p[i]);
      if (i < out_log.size()) chk("t2_out_order", out_log[i], t2o[i]);
    end

    // T3: backpressure limits pops to buffer depth
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) fq[0].push_back('hC0 + i);
    clear_logs();
    repeat (6) tick();
    chk("t3_pops_stalled", pop_log.size(), 3);
    chk("t3_vld_stalled", int'(out_vld), 1);
    chk("t3_head_stalled", int'(out_data), 'hC0);
    out_rdy = 1'b1;
    repeat (8) tick();
    chk("t3_nouts", out_log.size(), 4);
    for (int i = 0; i < out_log.size(); i++) chk("t3_order", out_log[i], 'hC0 + i);

    // T4: single active queue popped back-to-back
    for (int i = 0; i < 4; i++) fq[1].push_back('hD0 + i);
    clear_logs();
    repeat (8) tick();
    chk("t4_npops", pop_log.size(), 4);
    foreach (pop_log[i]) chk("t4_pop_q1", pop_log[i], 1);
    foreach (out_log[i]) chk("t4_out", out_log[i], 256 + 'hD0 + i);

    // T5: masking, then enable drop after a single pop
    pop_mask = 2'b01;
    fq[0].push_back('hE0); fq[0].push_back('hE1);
    fq[1].push_back('hF0); fq[1].push_back('hF1);
    clear_logs();
    repeat (8) tick();
    ones = 0;
    foreach (pop_log[i]) if (pop_log[i] == 1) ones++;
    chk("t5_masked_pops", ones, 0);
    chk("t5_npops", pop_log.size(), 2);
    pop_mask = 2'b11;
    for (int i = 0; i < 3; i++) fq[0].push_back('h10 + i);
    clear_logs();
    tick();
    enable = 1'b0;
    repeat (6) tick();
    chk("t5_en_pops", pop_log.size(), 1);
    chk("t5_en_outs", out_log.size(), 1);
    if (out_log.size() > 0) chk("t5_en_word", out_log[0], 256 + 'hF0);
    fq[0].delete(); fq[1].delete();
    enable = 1'b1;

    // T6: reset with one word in flight and two buffered
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) fq[0].push_back('h60 + i);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fq[0].delete();
    chk("t6_vld_after_rst", int'(out_vld), 0);
    out_rdy = 1'b1;
    fq[1].push_back('h71);
    fq[0].push_back('h70);
    clear_logs();
    tick();
    chk("t6_rr_reset", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
    repeat (5) tick();
    chk("t6_nouts", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t6_out0", out_log[0], 'h70);
      chk("t6_out1", out_log[1], 256 + 'h71);
    end

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      pop_mask = NF'($urandom);
      out_rdy  = ($urandom_range(0, 9) < 7);
      rst      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) != 0) begin
        int q;
        q = $urandom_range(0, NF - 1);
        if (fq[q].size() < 6) fq[q].push_back($urandom_range(0, 255));
      end
      if (pop_log.size() > 64) clear_logs();
      tick();
    end
    rst = 1'b0; enable = 1'b0; out_rdy = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
